// File: rtl/pifo_sram_top.sv
// Multi-port, multi-tree PIFO scheduler: per-port task FIFOs feed LEVEL sorted-array
// priority queues through per-tree round-robin dispatch.

module pifo_tree #(
    parameter int PTW   = 8,
    parameter int DW    = 8,
    parameter int CTW   = 8,
    parameter int DEPTH = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_vld,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_res
);
    logic [DEPTH-1:0][DW-1:0] r_mem, w_shl, w_base, w_nxt;
    logic [CTW-1:0]           r_cnt, w_bcnt, w_ncnt, w_pos;
    logic                     w_ins;
    logic [PTW-1:0]           w_ip;

    assign w_ip = i_data[DW-1 -: PTW];

    always_comb begin
        w_shl = '0;
        for (int i = 0; i < DEPTH-1; i++) w_shl[i] = r_mem[i+1];
    end

    // Any pop first builds a head-removed base array; an insert then lands after
    // all entries with priority <= incoming, which keeps ties in arrival order.
    always_comb begin
        o_res  = '0;
        w_base = r_mem;
        w_bcnt = r_cnt;
        w_ins  = 1'b0;
        if (i_vld) begin
            if (i_push && i_pop) begin
                if (r_cnt == '0 || w_ip < r_mem[0][DW-1 -: PTW]) begin
                    o_res = i_data;
                end else begin
                    o_res  = r_mem[0];
                    w_base = w_shl;
                    w_bcnt = r_cnt - CTW'(1);
                    w_ins  = 1'b1;
                end
            end else if (i_pop) begin
                if (r_cnt != '0) begin
                    o_res  = r_mem[0];
                    w_base = w_shl;
                    w_bcnt = r_cnt - CTW'(1);
                end
            end else if (i_push && r_cnt < CTW'(DEPTH)) begin
                w_ins = 1'b1;
            end
        end
        w_pos = '0;
        for (int i = 0; i < DEPTH; i++)
            if (CTW'(i) < w_bcnt && w_base[i][DW-1 -: PTW] <= w_ip) w_pos = w_pos + CTW'(1);
        w_nxt  = w_base;
        w_ncnt = w_bcnt;
        if (w_ins) begin
            w_ncnt = w_bcnt + CTW'(1);
            for (int i = 0; i < DEPTH; i++) begin
                if (CTW'(i) == w_pos)     w_nxt[i] = i_data;
                else if (CTW'(i) > w_pos) w_nxt[i] = w_base[(i == 0) ? 0 : i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem <= '0;
            r_cnt <= '0;
        end else begin
            r_mem <= w_nxt;
            r_cnt <= w_ncnt;
        end
    end
endmodule

module pifo_sram_top #(
    parameter int   PTW        = 8,
    parameter int   MTW        = 0,
    parameter int   CTW        = 8,
    parameter int   LEVEL      = 4,
    parameter int   DEPTH      = 16,
    parameter int   FIFO_DEPTH = 4,
    parameter int   TIDW       = (LEVEL > 1) ? $clog2(LEVEL) : 1,
    localparam int  DW         = PTW + MTW
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [LEVEL-1:0][TIDW-1:0] i_tree_id,
    input  logic [LEVEL-1:0]           i_push,
    input  logic [LEVEL-1:0][DW-1:0]   i_push_data,
    input  logic [LEVEL-1:0]           i_pop,
    output logic [LEVEL-1:0][DW-1:0]   o_pop_data,
    output logic [LEVEL-1:0]           o_task_fifo_full
);
    localparam int EW  = 2 + TIDW + DW;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    logic [LEVEL-1:0][FIFO_DEPTH-1:0][EW-1:0] r_fifo;
    logic [LEVEL-1:0][PW-1:0]   r_wptr, r_rptr;
    logic [LEVEL-1:0][FCW-1:0]  r_fcnt;
    logic [LEVEL-1:0][TIDW-1:0] r_rr;
    logic [LEVEL-1:0][DW-1:0]   r_pop_data;

    logic [LEVEL-1:0]           w_hval, w_hpush, w_hpop, w_enq, w_deq;
    logic [LEVEL-1:0][TIDW-1:0] w_htid, w_gidx;
    logic [LEVEL-1:0][DW-1:0]   w_hdata, w_tdata, w_tres;
    logic [LEVEL-1:0]           w_tvld, w_tpush, w_tpop;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    for (genvar j = 0; j < LEVEL; j++) begin : g_full
        assign o_task_fifo_full[j] = (r_fcnt[j] == FCW'(FIFO_DEPTH));
    end
    assign o_pop_data = r_pop_data;

    always_comb begin
        w_hpush = '0;
        w_hpop  = '0;
        w_htid  = '0;
        w_hdata = '0;
        w_hval  = '0;
        w_enq   = '0;
        for (int j = 0; j < LEVEL; j++) begin
            {w_hpush[j], w_hpop[j], w_htid[j], w_hdata[j]} = r_fifo[j][r_rptr[j]];
            w_hval[j] = (r_fcnt[j] != '0);
            w_enq[j]  = (i_push[j] || i_pop[j]) && !o_task_fifo_full[j];
        end
    end

    // Per tree: scan ports starting just after the last grant, first matching head wins.
    always_comb begin
        int k;
        k       = 0;
        w_gidx  = '0;
        w_tvld  = '0;
        w_tpush = '0;
        w_tpop  = '0;
        w_tdata = '0;
        w_deq   = '0;
        for (int t = 0; t < LEVEL; t++) begin
            for (int i = 1; i <= LEVEL; i++) begin
                k = (int'(r_rr[t]) + i) % LEVEL;
                if (!w_tvld[t] && w_hval[k] && int'(w_htid[k]) == t) begin
                    w_tvld[t]  = 1'b1;
                    w_gidx[t]  = TIDW'(k);
                    w_tpush[t] = w_hpush[k];
                    w_tpop[t]  = w_hpop[k];
                    w_tdata[t] = w_hdata[k];
                    w_deq[k]   = 1'b1;
                end
            end
        end
        // Heads aimed at a nonexistent tree just drain.
        for (int j = 0; j < LEVEL; j++)
            if (w_hval[j] && int'(w_htid[j]) >= LEVEL) w_deq[j] = 1'b1;
    end

    for (genvar t = 0; t < LEVEL; t++) begin : g_tree
        pifo_tree #(.PTW(PTW), .DW(DW), .CTW(CTW), .DEPTH(DEPTH)) u_tree (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_vld  (w_tvld[t]),
            .i_push (w_tpush[t]),
            .i_pop  (w_tpop[t]),
            .i_data (w_tdata[t]),
            .o_res  (w_tres[t])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fifo     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fcnt     <= '0;
            r_rr       <= '0;
            r_pop_data <= '0;
        end else begin
            for (int j = 0; j < LEVEL; j++) begin
                if (w_enq[j]) begin
                    r_fifo[j][r_wptr[j]] <= {i_push[j], i_pop[j], i_tree_id[j], i_push_data[j]};
                    r_wptr[j]            <= f_inc(r_wptr[j]);
                end
                if (w_deq[j]) begin
                    r_rptr[j] <= f_inc(r_rptr[j]);
                    if (w_hpop[j])
                        r_pop_data[j] <= (int'(w_htid[j]) < LEVEL) ? w_tres[w_htid[j]] : '0;
                end
                case ({w_enq[j], w_deq[j]})
                    2'b10:   r_fcnt[j] <= r_fcnt[j] + FCW'(1);
                    2'b01:   r_fcnt[j] <= r_fcnt[j] - FCW'(1);
                    default: r_fcnt[j] <= r_fcnt[j];
                endcase
            end
            for (int t = 0; t < LEVEL; t++)
                if (w_tvld[t]) r_rr[t] <= w_gidx[t];
        end
    end
endmodule

// File: tb/tb_pifo_sram_top.sv
// Directed bench for pifo_sram_top: reset, round trips, ordering, contention,
// full tree / full task FIFO, combined push+pop, reset mid-operation.

module tb_pifo_sram_top;
    logic            clk;
    logic            rst;
    logic [3:0][1:0] tree_id;
    logic [3:0]      push;
    logic [3:0][7:0] pdata;
    logic [3:0]      pop;
    logic [3:0][7:0] popd;
    logic [3:0]      full;

    int n_chk = 0;
    int n_bad = 0;

    pifo_sram_top dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_tree_id        (tree_id),
        .i_push           (push),
        .i_push_data      (pdata),
        .i_pop            (pop),
        .o_pop_data       (popd),
        .o_task_fifo_full (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One command on one port; returns at the negedge where its result is visible.
    task automatic op(input int p, input bit ps, input bit pp, input int tid, input int d);
        @(negedge clk);
        push[p]    = ps;
        pop[p]     = pp;
        tree_id[p] = 2'(tid);
        pdata[p]   = 8'(d);
        @(negedge clk);
        push = '0;
        pop  = '0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        push = '0;
        pop  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; push = '0; pop = '0; tree_id = '0; pdata = '0;

        do_reset();
        for (int j = 0; j < 4; j++) chk($sformatf("rst_pop%0d", j), popd[j], 0);
        chk("rst_full", full, 0);
        op(0, 0, 1, 0, 0);
        chk("rst_pop_empty", popd[0], 0);

        // all four ports in parallel, each on its own tree
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                push[j] = 1'b1; tree_id[j] = 2'(j); pdata[j] = 8'(i + 1 + 16*j);
            end
            @(negedge clk); push = '0;
            @(negedge clk);
            for (int j = 0; j < 4; j++) pop[j] = 1'b1;
            @(negedge clk); pop = '0;
            @(negedge clk);
            for (int j = 0; j < 4; j++) chk($sformatf("rt_i%0d_p%0d", i, j), popd[j], i + 1 + 16*j);
            chk($sformatf("rt_full_i%0d", i), full, 0);
        end

        op(0, 1, 0, 1, 9);
        op(0, 1, 0, 1, 3);
        op(0, 1, 0, 1, 7);
        op(0, 1, 0, 1, 3);
        op(0, 0, 1, 1, 0); chk("ord0", popd[0], 3);
        op(0, 0, 1, 1, 0); chk("ord1", popd[0], 3);
        op(0, 0, 1, 1, 0); chk("ord2", popd[0], 7);
        op(0, 0, 1, 1, 0); chk("ord3", popd[0], 9);
        op(0, 0, 1, 1, 0); chk("ord_empty", popd[0], 0);

        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            push[j] = 1'b1; tree_id[j] = 2'd0; pdata[j] = 8'(40 - 10*j);
        end
        @(negedge clk); push = '0;
        repeat (4) @(negedge clk);
        chk("cont_full", full, 0);
        for (int k = 0; k < 4; k++) begin
            op(0, 0, 1, 0, 0);
            chk($sformatf("cont_pop%0d", k), popd[0], 10*(k+1));
        end

        // 17th push lands on a full tree and must vanish
        for (int k = 0; k < 17; k++) op(2, 1, 0, 2, 100 - k);
        for (int k = 0; k < 16; k++) begin
            op(2, 0, 1, 2, 0);
            chk($sformatf("fullA_pop%0d", k), popd[2], 85 + k);
        end
        op(2, 0, 1, 2, 0);
        chk("fullA_empty", popd[2], 0);

        op(1, 1, 0, 1, 5);
        op(1, 1, 1, 1, 2); chk("comb_small", popd[1], 2);
        op(1, 1, 1, 1, 8); chk("comb_head", popd[1], 5);
        op(1, 0, 1, 1, 0); chk("comb_left", popd[1], 8);
        op(1, 0, 1, 1, 0); chk("comb_empty", popd[1], 0);
        op(1, 1, 1, 1, 7); chk("comb_on_empty", popd[1], 7);
        op(1, 0, 1, 1, 0); chk("comb_on_empty_tree", popd[1], 0);

        // saturate tree 0 from all ports; port 0 carries 1..5, others 200
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 5) chk("fullB_after4", full, 4'b0001);
            push = 4'hf; tree_id = '0;
            pdata[0] = 8'(k); pdata[1] = 8'd200; pdata[2] = 8'd200; pdata[3] = 8'd200;
        end
        @(negedge clk);
        chk("fullB_after5", full, 4'b1110);
        push = '0;
        repeat (25) @(negedge clk);
        chk("fullB_drained", full, 0);
        for (int k = 1; k <= 4; k++) begin
            op(0, 0, 1, 0, 0);
            chk($sformatf("fullB_pop%0d", k), popd[0], k);
        end
        op(0, 0, 1, 0, 0);
        chk("fullB_dropped5", popd[0], 200);

        // reset while tree 0 still holds entries and a push to tree 3 is in flight
        @(negedge clk);
        push[3] = 1'b1; tree_id[3] = 2'd3; pdata[3] = 8'd77;
        @(negedge clk);
        push = '0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_pop0", popd[0], 0);
        chk("midrst_full", full, 0);
        op(3, 0, 1, 3, 0); chk("midrst_t3", popd[3], 0);
        op(0, 0, 1, 0, 0); chk("midrst_t0", popd[0], 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
